mult_scheduler: RTL and testbench

- Shares one sequential multiplier datapath and its controller among NUM_REQ requesters.
- Picks one requester per operation with a round-robin policy and latches its operands.
- Issues a start pulse to the multiplier, waits for completion, and returns the product tagged with the requester index.
- Sits between client blocks and the multiplier wrapper; operands of zero bypass the datapath entirely.

---
 rtl/mult_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/mult_scheduler.sv | 151 +++++++++++++++
 tb/tb_mult_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and defaults for the multiplier scheduler and its round-robin arbiter.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or above ptr,
// wrapping around, and reports it both one-hot and encoded.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  // ptr + k stays below 2*NUM_REQ, so one extra bit and a single subtract do the wrap
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (w_sum >= NUM_REQ_W) begin
        w_sum = w_sum - NUM_REQ_W;
      end
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_id     = w_idx;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one sequential multiplier among NUM_REQ requesters with round-robin selection;
// a zero operand skips the multiplier and answers 0 directly.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     mul_ready,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic                     mul_done,
  input  logic [2*WIDTH-1:0]       mul_product,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     busy
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  sched_state_t       r_state;
  sched_state_t       w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [2*WIDTH-1:0] r_product;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic               w_any;
  logic               w_zero;
  logic [ID_W-1:0]    w_next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (r_rr_ptr),
    .grant    (w_grant),
    .grant_id (w_grant_id)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_a[i*WIDTH +: WIDTH];
        w_sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_any      = |req_valid;
  assign w_zero     = (w_sel_a == '0) || (w_sel_b == '0);
  assign w_next_ptr = (r_id == LAST_ID) ? '0 : r_id + 1'b1;

  // req_ready is also gated by reset so every output reads 0 while reset is held
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    mul_start    = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (reset) begin
          req_ready = w_grant;
        end
        if (w_any) begin
          w_state_next = w_zero ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (mul_ready) begin
          mul_start    = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (mul_done) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= '0;
      r_rr_ptr  <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
            r_id <= w_grant_id;
            if (w_zero) begin
              r_product <= '0;
            end
          end
        end
        WAIT: begin
          if (mul_done) begin
            r_product <= mul_product;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: ;
      endcase
    end
  end

  assign mul_a       = r_a;
  assign mul_b       = r_b;
  assign rsp_id      = r_id;
  assign rsp_product = r_product;

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler: a queue-based scoreboard is filled at each grant and
// drained by a monitor that compares every accepted response.
module tb_mult_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     mul_ready;
  logic                     mul_start;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic                     mul_done;
  logic [2*WIDTH-1:0]       mul_product;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [2*WIDTH-1:0]       rsp_product;
  logic                     busy;

  int checks = 0;
  int errors = 0;
  int startCount = 0;
  int expIdQ[$];
  logic [2*WIDTH-1:0] expProdQ[$];
  int headId;
  logic [2*WIDTH-1:0] headProd;
  int validSeen;

  mult_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .mul_ready   (mul_ready),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int g, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[g*WIDTH +: WIDTH] = a;
    req_b[g*WIDTH +: WIDTH] = b;
    req_valid[g] = 1'b1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Serves one operation from grant to response acceptance; returns in the following IDLE cycle
  task automatic serveOne(input int g, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2*WIDTH-1:0] prod, input int busyCycles,
                          input int holdCycles, input int latency, input bit clearAfter);
    int n;
    int startsBefore;
    n = 0;
    #1;
    while (req_ready == '0 && n < 20) begin
      nextCycle();
      n++;
    end
    checkOutput("grant", req_ready, 64'(1 << g));
    expIdQ.push_back(g);
    expProdQ.push_back(prod);
    startsBefore = startCount;
    nextCycle();
    if (clearAfter) req_valid[g] = 1'b0;
    if (a == '0 || b == '0) begin
      checkOutput("bypass_rsp_valid", rsp_valid, 1);
    end else begin
      for (int i = 0; i < busyCycles; i++) begin
        mul_ready   = 1'b0;
        mul_done    = (i == 0);
        mul_product = 32'hDEADBEEF;
        #1;
        checkOutput("start_while_busy", mul_start, 0);
        nextCycle();
      end
      mul_done    = 1'b0;
      mul_ready   = 1'b1;
      #1;
      checkOutput("mul_start", mul_start, 1);
      checkOutput("mul_a", mul_a, a);
      checkOutput("mul_b", mul_b, b);
      nextCycle();
      checkOutput("wait_no_start", mul_start, 0);
      repeat (latency - 1) nextCycle();
      mul_done    = 1'b1;
      mul_product = prod;
      nextCycle();
      mul_done    = 1'b0;
      mul_product = '0;
    end
    if (holdCycles > 0) begin
      rsp_ready = 1'b0;
      for (int i = 0; i < holdCycles; i++) begin
        checkOutput("hold_rsp_valid", rsp_valid, 1);
        checkOutput("hold_rsp_id", rsp_id, g);
        checkOutput("hold_rsp_product", rsp_product, prod);
        checkOutput("hold_req_ready", req_ready, 0);
        nextCycle();
      end
      rsp_ready = 1'b1;
      #1;
    end
    checkOutput("rsp_valid", rsp_valid, 1);
    checkOutput("no_accept_in_resp", req_ready, 0);
    nextCycle();
    checkOutput("idle_busy", busy, 0);
    checkOutput("scoreboard_drained", expIdQ.size(), 0);
    checkOutput("start_count", startCount - startsBefore, (a == '0 || b == '0) ? 0 : 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mul_start) startCount++;
    end
  end

  // Monitor: every accepted response must match the oldest expected entry
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (expIdQ.size() == 0) begin
          checkOutput("unexpected_rsp", 1, 0);
        end else begin
          headId   = expIdQ.pop_front();
          headProd = expProdQ.pop_front();
          checkOutput("rsp_id", rsp_id, headId);
          checkOutput("rsp_product", rsp_product, headProd);
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL timeout: got running, expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    reset       = 1'b0;
    req_valid   = '0;
    req_a       = '0;
    req_b       = '0;
    mul_ready   = 1'b1;
    mul_done    = 1'b0;
    mul_product = '0;
    rsp_ready   = 1'b1;
    repeat (2) nextCycle();
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_mul_start", mul_start, 0);
    checkOutput("reset_mul_a", mul_a, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_rsp_product", rsp_product, 0);
    checkOutput("reset_busy", busy, 0);
    reset = 1'b1;
    nextCycle();

    $display("[TB] round-robin with all requesters active");
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, WIDTH'(i + 2), WIDTH'(i + 3));
    serveOne(0, 16'd2, 16'd3, 32'd6,  0, 0, 1, 1'b0);
    serveOne(1, 16'd3, 16'd4, 32'd12, 0, 0, 2, 1'b0);
    serveOne(2, 16'd4, 16'd5, 32'd20, 0, 0, 1, 1'b0);
    serveOne(3, 16'd5, 16'd6, 32'd30, 0, 0, 3, 1'b0);
    serveOne(0, 16'd2, 16'd3, 32'd6,  0, 0, 1, 1'b0);
    req_valid = '0;

    $display("[TB] single request");
    applyStimulus(2, 16'd7, 16'd9);
    serveOne(2, 16'd7, 16'd9, 32'd63, 0, 0, 2, 1'b1);

    $display("[TB] zero bypass");
    applyStimulus(1, 16'd0, 16'd1234);
    serveOne(1, 16'd0, 16'd1234, 32'd0, 0, 0, 1, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(3, 16'd3, 16'd5);
    applyStimulus(0, 16'd0, 16'd5);
    serveOne(3, 16'd3, 16'd5, 32'd15, 0, 5, 1, 1'b1);
    serveOne(0, 16'd0, 16'd5, 32'd0,  0, 0, 1, 1'b1);

    $display("[TB] busy multiplier with stray done");
    applyStimulus(1, 16'd11, 16'd13);
    serveOne(1, 16'd11, 16'd13, 32'd143, 3, 0, 1, 1'b1);

    $display("[TB] maximum operands");
    applyStimulus(3, 16'hFFFF, 16'hFFFF);
    serveOne(3, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 0, 2, 1'b1);

    $display("[TB] reset during WAIT");
    applyStimulus(0, 16'd5, 16'd6);
    #1;
    checkOutput("rst_grant", req_ready, 1);
    nextCycle();
    req_valid = '0;
    checkOutput("rst_issue_start", mul_start, 1);
    nextCycle();
    checkOutput("rst_wait_busy", busy, 1);
    reset = 1'b0;
    req_valid = 4'b0010;
    #1;
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_mul_start", mul_start, 0);
    checkOutput("rst_mul_a", mul_a, 0);
    checkOutput("rst_mul_b", mul_b, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    checkOutput("rst_rsp_product", rsp_product, 0);
    checkOutput("rst_busy", busy, 0);
    req_valid = '0;
    nextCycle();
    reset = 1'b1;
    nextCycle();
    mul_done    = 1'b1;
    mul_product = 32'd30;
    nextCycle();
    mul_done    = 1'b0;
    validSeen   = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) validSeen++;
      nextCycle();
    end
    checkOutput("post_reset_no_rsp", validSeen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
